// File: rtl/pcie_us_cfg_fc_poll.sv
// pcie_us_cfg_fc_poll
// Sequenced poller for the UltraScale PCIe hard-IP flow-control status port.
// It steps cfg_fc_sel through the enabled codes and holds each code for a settle delay.
// It then captures the six credit fields into a per-code snapshot.
// It flags low posted / non-posted header credits from the latest code-4 sample.
// Optional build macro: PCIE_FC_POLL_MIN_TRACK_EN adds code-4 header low-water marks on min_hdr.
// Handshake: sweep_req is a fire-and-forget request pulse with no ready/backpressure.
//   In IDLE it starts a sweep on the next cycle. During a sweep it is remembered one-deep,
//   and repeats coalesce. sweep_done is a one-cycle completion pulse with no acknowledge.
module pcie_us_cfg_fc_poll #(
    parameter int         HDR_WIDTH      = 8,
    parameter int         DATA_WIDTH     = 12,
    parameter logic [7:0] SEL_MASK       = 8'b0111_0111,
    parameter int         SETTLE_CYCLES  = 2,
    parameter int         POLL_INTERVAL  = 256,
    parameter int         PH_LOW_THRESH  = 4,
    parameter int         NPH_LOW_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HDR_WIDTH-1:0]       cfg_fc_ph,
    input  logic [DATA_WIDTH-1:0]      cfg_fc_pd,
    input  logic [HDR_WIDTH-1:0]       cfg_fc_nph,
    input  logic [DATA_WIDTH-1:0]      cfg_fc_npd,
    input  logic [HDR_WIDTH-1:0]       cfg_fc_cplh,
    input  logic [DATA_WIDTH-1:0]      cfg_fc_cpld,
    output logic [2:0]                 cfg_fc_sel,
    input  logic                       sweep_req,
    output logic [8*3*HDR_WIDTH-1:0]   snap_hdr,
    output logic [8*3*DATA_WIDTH-1:0]  snap_data,
    output logic [7:0]                 snap_valid,
    output logic                       sweep_done,
    output logic                       tx_p_low,
    output logic                       tx_np_low,
    input  logic                       min_clear,
    output logic [3*HDR_WIDTH-1:0]     min_hdr,
    output logic [1:0]                 dbg_state
);

    // Codes 3 and 7 are reserved on the hard IP and are never polled.
    localparam logic [7:0] EFF_MASK = SEL_MASK & 8'b0111_0111;
    localparam int HW3 = 3 * HDR_WIDTH;
    localparam int DW3 = 3 * DATA_WIDTH;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam int ICW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [ICW-1:0] INTERVAL_LAST = ICW'((POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0);
    localparam logic [HDR_WIDTH-1:0] PH_THR  = HDR_WIDTH'(PH_LOW_THRESH);
    localparam logic [HDR_WIDTH-1:0] NPH_THR = HDR_WIDTH'(NPH_LOW_THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SET    = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Lowest enabled code strictly above 'above'; bit 3 flags that one exists.
    function automatic logic [3:0] next_enabled(input int above);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (EFF_MASK[i] && (i > above)) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    state_t                 state_q;
    logic [2:0]             sel_q;
    logic [SCW-1:0]         settle_cnt_q;
    logic [ICW-1:0]         interval_cnt_q;
    logic                   pend_q;
    logic [8*HW3-1:0]       snap_hdr_q;
    logic [8*DW3-1:0]       snap_data_q;
    logic [7:0]             snap_valid_q;
    logic                   sweep_done_q;
    logic                   tx_p_low_q;
    logic                   tx_np_low_q;

    logic [3:0]             first_d;
    logic [3:0]             next_d;
    logic                   interval_tc_d;
    logic                   start_d;
    logic                   sample4_d;

    // Sweep start decision and code sequencing.
    always_comb begin
        first_d       = next_enabled(-1);
        next_d        = next_enabled(int'(sel_q));
        interval_tc_d = (POLL_INTERVAL != 0) && (interval_cnt_q == INTERVAL_LAST);
        start_d       = first_d[3] && (sweep_req || pend_q || interval_tc_d);
        sample4_d     = (state_q == S_SAMPLE) && (sel_q == 3'd4);
    end

    // Poll FSM with its registered outputs; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sel_q          <= 3'd4;
            settle_cnt_q   <= '0;
            interval_cnt_q <= '0;
            pend_q         <= 1'b0;
            snap_hdr_q     <= '0;
            snap_data_q    <= '0;
            snap_valid_q   <= '0;
            sweep_done_q   <= 1'b0;
            tx_p_low_q     <= 1'b0;
            tx_np_low_q    <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            if ((state_q != S_IDLE) && sweep_req) pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q        <= S_SET;
                        sel_q          <= first_d[2:0];
                        settle_cnt_q   <= '0;
                        interval_cnt_q <= '0;
                        pend_q         <= 1'b0;
                    end else if (POLL_INTERVAL != 0) begin
                        interval_cnt_q <= interval_tc_d ? '0 : interval_cnt_q + 1'b1;
                    end
                end
                S_SET: begin
                    if (settle_cnt_q == SETTLE_LAST) state_q <= S_SAMPLE;
                    else settle_cnt_q <= settle_cnt_q + 1'b1;
                end
                S_SAMPLE: begin
                    snap_hdr_q[sel_q*HW3 +: HW3]  <= {cfg_fc_cplh, cfg_fc_nph, cfg_fc_ph};
                    snap_data_q[sel_q*DW3 +: DW3] <= {cfg_fc_cpld, cfg_fc_npd, cfg_fc_pd};
                    snap_valid_q[sel_q]           <= 1'b1;
                    if (sample4_d) begin
                        tx_p_low_q  <= (cfg_fc_ph < PH_THR);
                        tx_np_low_q <= (cfg_fc_nph < NPH_THR);
                    end
                    if (next_d[3]) begin
                        state_q      <= S_SET;
                        sel_q        <= next_d[2:0];
                        settle_cnt_q <= '0;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    sweep_done_q   <= 1'b1;
                    interval_cnt_q <= '0;
                    state_q        <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_fc_sel = sel_q;
    assign snap_hdr   = snap_hdr_q;
    assign snap_data  = snap_data_q;
    assign snap_valid = snap_valid_q;
    assign sweep_done = sweep_done_q;
    assign tx_p_low   = tx_p_low_q;
    assign tx_np_low  = tx_np_low_q;
    assign dbg_state  = state_q;

`ifdef PCIE_FC_POLL_MIN_TRACK_EN
    logic [HW3-1:0] min_hdr_q;

    // Code-4 header credit low-water marks; a same-cycle sample wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_hdr_q <= '1;
        end else if (sample4_d) begin
            if (min_clear) begin
                min_hdr_q <= {cfg_fc_cplh, cfg_fc_nph, cfg_fc_ph};
            end else begin
                if (cfg_fc_ph < min_hdr_q[0 +: HDR_WIDTH])
                    min_hdr_q[0 +: HDR_WIDTH] <= cfg_fc_ph;
                if (cfg_fc_nph < min_hdr_q[HDR_WIDTH +: HDR_WIDTH])
                    min_hdr_q[HDR_WIDTH +: HDR_WIDTH] <= cfg_fc_nph;
                if (cfg_fc_cplh < min_hdr_q[2*HDR_WIDTH +: HDR_WIDTH])
                    min_hdr_q[2*HDR_WIDTH +: HDR_WIDTH] <= cfg_fc_cplh;
            end
        end else if (min_clear) begin
            min_hdr_q <= '1;
        end
    end

    assign min_hdr = min_hdr_q;
`else
    logic unused_min_clear;
    assign unused_min_clear = min_clear;
    assign min_hdr          = '1;
`endif

endmodule
